// File: rtl/store_monitor.sv
// ============================================================================
// store_monitor : snoops core data-memory stores into a FIFO drained over a
//                 valid/ready stream; flags completion, misalignment, overflow.
// Revision 1.0
// ============================================================================
`default_nettype none

module store_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] PASS_ADR  = 32'd100,
    parameter logic [31:0] PASS_DATA = 32'd7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [31:0]              OutAdr,
    output logic [31:0]              OutData,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic [15:0]              DropCnt,
    output logic                     Misaligned,
    output logic                     Done,
    output logic                     Pass
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   adr_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic push;
    logic pop;
    logic accept;

    assign push   = MemWrite;
    assign pop    = OutValid & OutReady;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign accept = push & ((count < CW'(DEPTH)) | pop);

    assign OutValid = (count != '0);
    assign OutAdr   = OutValid ? adr_mem[rd_ptr]  : 32'd0;
    assign OutData  = OutValid ? data_mem[rd_ptr] : 32'd0;
    assign Count    = count;

    // Storage needs no reset: stale entries are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            adr_mem[wr_ptr]  <= DataAdr;
            data_mem[wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            Overflow   <= 1'b0;
            DropCnt    <= 16'd0;
            Misaligned <= 1'b0;
            Done       <= 1'b0;
            Pass       <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !accept) begin
                count <= count - CW'(1);
            end

            if (push && !accept) begin
                Overflow <= 1'b1;
                if (DropCnt != 16'hFFFF) begin
                    DropCnt <= DropCnt + 16'd1;
                end
            end

            if (push && (DataAdr[1:0] != 2'b00)) begin
                Misaligned <= 1'b1;
            end

            // Only the first completion store decides the verdict.
            if (push && !Done && (DataAdr == PASS_ADR)) begin
                Done <= 1'b1;
                Pass <= (WriteData == PASS_DATA);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_monitor.sv
// ============================================================================
// tb_store_monitor : directed + randomized checks of store_monitor against a
//                    queue-based reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_store_monitor;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWrite;
    logic [31:0]   DataAdr;
    logic [31:0]   WriteData;
    logic          OutValid;
    logic          OutReady;
    logic [31:0]   OutAdr;
    logic [31:0]   OutData;
    logic [CW-1:0] Count;
    logic          Overflow;
    logic [15:0]   DropCnt;
    logic          Misaligned;
    logic          Done;
    logic          Pass;

    always #5 clk = ~clk;

    store_monitor #(
        .DEPTH     (DEPTH),
        .PASS_ADR  (32'd100),
        .PASS_DATA (32'd7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutAdr     (OutAdr),
        .OutData    (OutData),
        .Count      (Count),
        .Overflow   (Overflow),
        .DropCnt    (DropCnt),
        .Misaligned (Misaligned),
        .Done       (Done),
        .Pass       (Pass)
    );

    // Reference model: a queue of {address, data} plus the sticky flags.
    logic [63:0] q [$];
    bit          m_ovf;
    bit          m_mis;
    bit          m_done;
    bit          m_pass;
    int          m_drop;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : 64'd0;
        chk("OutValid",   32'(OutValid),   32'(q.size() != 0));
        chk("OutAdr",     OutAdr,          head[63:32]);
        chk("OutData",    OutData,         head[31:0]);
        chk("Count",      32'(Count),      32'(q.size()));
        chk("Overflow",   32'(Overflow),   32'(m_ovf));
        chk("DropCnt",    32'(DropCnt),    32'(m_drop));
        chk("Misaligned", 32'(Misaligned), 32'(m_mis));
        chk("Done",       32'(Done),       32'(m_done));
        chk("Pass",       32'(Pass),       32'(m_pass));
    endtask

    // Advance the model with the inputs present before the edge, clock, then compare.
    task automatic tick();
        if (!reset) begin
            q.delete();
            m_ovf  = 0;
            m_mis  = 0;
            m_done = 0;
            m_pass = 0;
            m_drop = 0;
        end else begin
            if (q.size() != 0 && OutReady) void'(q.pop_front());
            if (MemWrite) begin
                if (q.size() < DEPTH) begin
                    q.push_back({DataAdr, WriteData});
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                if (DataAdr[1:0] != 2'b00) m_mis = 1;
                if (DataAdr == 32'd100 && !m_done) begin
                    m_done = 1;
                    m_pass = (WriteData == 32'd7);
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
    endtask

    task automatic idle();
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
    endtask

    initial begin
        reset    = 1'b0;
        OutReady = 1'b0;
        idle();
        m_ovf = 0; m_mis = 0; m_done = 0; m_pass = 0; m_drop = 0;

        // Reset hold, then idle cycles with everything at zero.
        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();

        // Reset held over an active store stream keeps the FIFO empty.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'h200 + 32'(4 * i), $urandom);
            tick();
        end
        chk("rst_stream_count", 32'(Count), 32'd0);
        idle();
        reset = 1'b1;
        tick();

        // Single store then a one-cycle drain.
        store(32'h60, 32'h11);
        tick();
        idle();
        chk("single_adr",  OutAdr,  32'h60);
        chk("single_data", OutData, 32'h11);
        tick();
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        chk("single_drained", 32'(OutValid), 32'd0);

        // Ten back-to-back stores into an eight-deep FIFO.
        for (int i = 0; i < 10; i++) begin
            store(32'(4 * i), 32'(i));
            tick();
        end
        chk("fill_count", 32'(Count),   32'd8);
        chk("fill_drop",  32'(DropCnt), 32'd2);
        chk("fill_ovf",   32'(Overflow), 32'd1);

        // Full FIFO with simultaneous store and pop: nothing dropped.
        store(32'h80, 32'hAA);
        OutReady = 1'b1;
        tick();
        idle();
        chk("full_pp_count", 32'(Count),   32'd8);
        chk("full_pp_drop",  32'(DropCnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", OutData, (i < 7) ? 32'(i + 1) : 32'hAA);
            tick();
        end

        // Completion store with pass data, then a later one that must be ignored.
        store(32'd100, 32'd7);
        tick();
        chk("done_first", 32'(Done), 32'd1);
        chk("pass_first", 32'(Pass), 32'd1);
        store(32'h104, 32'h3);
        tick();
        store(32'd100, 32'd9);
        tick();
        idle();
        chk("pass_sticky", 32'(Pass), 32'd1);

        // Fresh run: completion with the wrong data.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        OutReady = 1'b0;
        store(32'd100, 32'd5);
        tick();
        idle();
        chk("fail_done", 32'(Done), 32'd1);
        chk("fail_pass", 32'(Pass), 32'd0);

        // Misaligned store is flagged and captured unmodified.
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        store(32'h62, 32'h1234);
        tick();
        idle();
        chk("mis_flag", 32'(Misaligned), 32'd1);
        chk("mis_adr",  OutAdr,          32'h62);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mis_cleared", 32'(Misaligned), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 79) != 0);
            OutReady = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0) begin
                logic [31:0] a;
                case ($urandom_range(0, 9))
                    0:       a = 32'd100;
                    1:       a = $urandom;
                    default: a = {$urandom_range(0, 255), 2'b00};
                endcase
                store(a, ($urandom_range(0, 1) != 0) ? 32'd7 : $urandom);
            end else begin
                idle();
            end
            tick();
        end

        reset = 1'b1;
        idle();
        OutReady = 1'b1;
        repeat (DEPTH + 1) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Sits directly downstream of the single-cycle ARM core's data-memory write port, in parallel with dmem.
- Snoops every store (MemWrite, DataAdr, WriteData) and buffers it in a FIFO.
- Drains the FIFO over a valid/ready stream to the test harness or a debug UART.
- Flags the program's completion store (pass/fail), misaligned stores, and FIFO overflow.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of two and at least 2.
- PASS_ADR, 32'd100: store address that marks program completion.
- PASS_DATA, 32'd7: data value at PASS_ADR that signals pass.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- MemWrite  in  1  core store strobe; a store occurs on each rising clk edge where it is 1.
- DataAdr  in  32  store byte address.
- WriteData  in  32  store data.
- OutValid  out  1  head FIFO entry available.
- OutReady  in  1  consumer accepts the head entry.
- OutAdr  out  32  address of the head entry.
- OutData  out  32  data of the head entry.
- Count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- Overflow  out  1  sticky; at least one store was dropped.
- DropCnt  out  16  number of dropped stores, saturating.
- Misaligned  out  1  sticky; a store with DataAdr[1:0] != 0 was seen.
- Done  out  1  sticky; a completion store was seen.
- Pass  out  1  valid when Done=1; 1 if the completion data matched PASS_DATA.

Behaviour:
- Reset (reset=0 at a rising edge):
  - FIFO emptied, read/write pointers set to 0.
  - Count=0, OutValid=0, OutAdr=0, OutData=0.
  - Overflow=0, DropCnt=0, Misaligned=0, Done=0, Pass=0.
  - Reset asserted mid-operation discards all buffered entries and flags with no drain; a store on the reset edge is ignored.
- Push: push = MemWrite. The store {DataAdr, WriteData} is written at the tail on the same edge.
- Pop: pop = OutValid & OutReady. The head pointer advances on the edge.
- Output path:
  - OutAdr/OutData always reflect the head entry; they are 0 when empty.
  - OutValid = (Count != 0).
  - Latency: a store into an empty FIFO at edge N gives OutValid=1 with that entry after edge N.
- Accept rule: a push is accepted if Count < DEPTH, or if a pop occurs in the same cycle.
  - Full FIFO with simultaneous push and pop: both happen, Count stays DEPTH, order is preserved.
  - Empty FIFO: no pop is possible, so a push in the same cycle is simply accepted.
- Drop: a push that is not accepted leaves FIFO contents unchanged.
  - Overflow is set to 1.
  - DropCnt increments and saturates at 16'hFFFF (no wrap).
- Count is updated as: +1 on accepted push only, -1 on pop only, unchanged on both or neither.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty is derived from Count, not from pointer equality.
- Misaligned:
  - Set on any store with DataAdr[1:0] != 2'b00.
  - The store is still captured unmodified.
- Completion:
  - The first store with DataAdr == PASS_ADR sets Done=1.
  - On the same edge, Pass = (WriteData == PASS_DATA).
  - Later stores to PASS_ADR do not change Done or Pass.
  - The completion store is also captured in the FIFO, or dropped, like any other store.
- Flags never clear except on reset.
- Backpressure does not stall the core. MemWrite is never gated; buffering is observational only.

Test Plan:
- Reset hold then release, no stores: all outputs 0 for 5 cycles. With reset=0 asserted over an active store stream, Count stays 0.
- Single store ADR=0x60, DATA=0x11, OutReady=0:
  - next cycle OutValid=1, OutAdr=0x60, OutData=0x11, Count=1;
  - assert OutReady for one cycle, then OutValid=0, Count=0.
- 10 back-to-back stores (ADR=4*i, DATA=i) with OutReady=0 and DEPTH=8:
  - Count=8, Overflow=1, DropCnt=2;
  - draining returns DATA 0..7 in order.
- Full FIFO plus simultaneous store (0x80, 0xAA) and OutReady=1: Count stays 8, DropCnt is unchanged, and 0xAA emerges eighth.
- Store 7 to address 100, then later store 9 to address 100: Done=1 and Pass=1 after the first, both unchanged after the second. On a fresh run, storing 5 to address 100 gives Done=1, Pass=0.
- Store to ADR=0x62 gives Misaligned=1 with the entry captured as 0x62. After reset, Misaligned=0.
